// File: rtl/bcd_updown_counter.sv
// Parametrised N-digit BCD up/down counter with parallel load and a wrap or saturate boundary mode.
// bcd and tc are the only state; zero is decoded combinationally from bcd.
module bcd_updown_counter #(
   parameter int DIGITS = 3,
   parameter bit WRAP   = 1'b1
) (
   input  logic                  ck,
   input  logic                  rs,
   input  logic                  en,
   input  logic                  up,
   input  logic                  ld,
   input  logic [4*DIGITS-1:0]   ld_val,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  tc,
   output logic                  zero
);

   logic [4*DIGITS-1:0] step_val;
   logic [4*DIGITS-1:0] load_val;
   logic                carry;
   logic                boundary;

   // Ripple carry/borrow: a digit only moves while the chain below it has
   // rolled over, so a carry out of the top digit marks the boundary step.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      step_val = bcd;
      load_val = ld_val;
      carry    = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (ld_val[4*k +: 4] > 4'd9)
            load_val[4*k +: 4] = 4'd9;
         if (carry) begin
            if (up) begin
               if (bcd[4*k +: 4] == 4'd9) begin
                  step_val[4*k +: 4] = 4'd0;
               end else begin
                  step_val[4*k +: 4] = bcd[4*k +: 4] + 4'd1;
                  carry              = 1'b0;
               end
            end else begin
               if (bcd[4*k +: 4] == 4'd0) begin
                  step_val[4*k +: 4] = 4'd9;
               end else begin
                  step_val[4*k +: 4] = bcd[4*k +: 4] - 4'd1;
                  carry              = 1'b0;
               end
            end
         end
      end
      boundary = carry;
   end

   // Wrapping falls out of the digit arithmetic; saturation just refuses the boundary step.
   always_ff @(posedge ck) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (rs) begin
         bcd <= '0;
         tc  <= 1'b0;
      end else if (ld) begin
         bcd <= load_val;
         tc  <= 1'b0;
      end else if (en) begin
         tc <= boundary;
         if (WRAP || !boundary)
            bcd <= step_val;
      end else begin
         tc <= 1'b0;
      end
   end

   assign zero = (bcd == '0);

endmodule
